// File: rtl/irq_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module   : irq_timer_slave
//  Purpose  : Strobe/acknowledge bus responder holding a 4-source
//             pending/enable interrupt controller. Source 0 is an internal
//             32-bit down-counting timer; sources 1..3 are rising-edge
//             detected external inputs.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1   rising-edge clock
//    rst_ni   in   1   asynchronous active-low reset
//    stb_i    in   1   bus strobe
//    we_i     in   1   1 = write, 0 = read
//    adr_i    in  32   byte address; [31:8] window decode, [4:2] register
//    dat_i    in  32   write data
//    sel_i    in   4   byte-lane enables
//    dat_o    out 32   read data, held until the next accepted read
//    ack_o    out  1   one-cycle acknowledge
//    src_i    in   3   external interrupt sources (synchronous to clk)
//    irq      out  4   interrupt request = pending & enable
//    irqack   in   4   one-hot interrupt acknowledge
// ----------------------------------------------------------------------------
//  Register map (offset)
//    0x00 STATUS [3:0]  pending bits, write-1-to-clear (lane 0)
//    0x04 ENABLE [3:0]  per-source mask
//    0x08 CNT    [31:0] timer count
//    0x0C RELOAD [31:0] timer reload value
//    0x10 CTRL   [1:0]  bit0 EN, bit1 AR (auto-reload)
//    0x14-0x1C          read 0, writes ignored, acknowledged
// ============================================================================
module irq_timer_slave #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst_ni,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [31:0] adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    input  logic [2:0]  src_i,
    output logic [3:0]  irq,
    input  logic [3:0]  irqack
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_ENABLE = 3'd1;
    localparam logic [2:0] REG_CNT    = 3'd2;
    localparam logic [2:0] REG_RELOAD = 3'd3;
    localparam logic [2:0] REG_CTRL   = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]  state_q,    state_d;
    logic [31:0] dat_o_q,    dat_o_d;
    logic [3:0]  pending_q,  pending_d;
    logic [3:0]  enable_q,   enable_d;
    logic [31:0] cnt_q,      cnt_d;
    logic [31:0] reload_q,   reload_d;
    logic [1:0]  ctrl_q,     ctrl_d;
    logic [2:0]  src_prev_q, src_prev_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       w_hit;
    logic       w_accept;
    logic       w_wr;
    logic [2:0] w_reg;
    logic [31:0] w_rd_data;

    assign w_hit = (adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_reg = adr_i[4:2];
    assign w_wr  = w_accept & we_i;

    // Address bits that take no part in decode; offsets 0x20-0xFF alias
    // the 0x00-0x1C block.
    logic unused_adr;
    assign unused_adr = ^{adr_i[7:5], adr_i[1:0]};

    // Byte-lane merge of write data into an existing 32-bit value.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old_val,
        input logic [31:0] wr_val,
        input logic [3:0]  lanes
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                res[8*i +: 8] = wr_val[8*i +: 8];
            end
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Bus FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (stb_i && w_hit) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                // The initiator keeps the strobe up after seeing ack; wait
                // for it to drop so the same request is not taken twice.
                if (!stb_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_accept = 1'b0;
        ack_o    = 1'b0;
        case (state_q)
            ST_IDLE: w_accept = stb_i & w_hit;
            ST_ACK:  ack_o    = 1'b1;
            default: begin
                w_accept = 1'b0;
                ack_o    = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Read mux and read-data holding register
    // ------------------------------------------------------------------
    always_comb begin
        w_rd_data = 32'd0;
        case (w_reg)
            REG_STATUS: w_rd_data = {28'd0, pending_q};
            REG_ENABLE: w_rd_data = {28'd0, enable_q};
            REG_CNT:    w_rd_data = cnt_q;
            REG_RELOAD: w_rd_data = reload_q;
            REG_CTRL:   w_rd_data = {30'd0, ctrl_q};
            default:    w_rd_data = 32'd0;
        endcase
    end

    always_comb begin
        dat_o_d = dat_o_q;
        if (w_accept && !we_i) begin
            dat_o_d = w_rd_data;
        end
    end

    assign dat_o = dat_o_q;

    // ------------------------------------------------------------------
    // Timer and configuration registers
    // ------------------------------------------------------------------
    logic w_timer_expire;

    always_comb begin
        cnt_d          = cnt_q;
        ctrl_d         = ctrl_q;
        enable_d       = enable_q;
        reload_d       = reload_q;
        w_timer_expire = 1'b0;

        if (ctrl_q[0]) begin
            if (cnt_q != 32'd0) begin
                cnt_d = cnt_q - 32'd1;
            end else begin
                w_timer_expire = 1'b1;
                if (ctrl_q[1]) begin
                    cnt_d = reload_q;
                end else begin
                    // One-shot: stop and leave the count parked at zero.
                    ctrl_d[0] = 1'b0;
                end
            end
        end

        // A bus write lands on top of the timer update for its lanes.
        if (w_wr) begin
            case (w_reg)
                REG_ENABLE: begin
                    if (sel_i[0]) begin
                        enable_d = dat_i[3:0];
                    end
                end
                REG_CNT:    cnt_d    = lane_merge(cnt_d, dat_i, sel_i);
                REG_RELOAD: reload_d = lane_merge(reload_q, dat_i, sel_i);
                REG_CTRL: begin
                    if (sel_i[0]) begin
                        ctrl_d = dat_i[1:0];
                    end
                end
                default: begin
                    cnt_d = cnt_d;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Interrupt pending logic
    // ------------------------------------------------------------------
    logic [3:0] w_set;
    logic [3:0] w_clr;

    always_comb begin
        src_prev_d = src_i;
        w_set      = {src_i & ~src_prev_q, w_timer_expire};
        w_clr      = irqack;
        if (w_wr && (w_reg == REG_STATUS) && sel_i[0]) begin
            w_clr = w_clr | dat_i[3:0];
        end
        // New events take priority over a simultaneous clear.
        pending_d = w_set | (pending_q & ~w_clr);
    end

    assign irq = pending_q & enable_q;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_o_q    <= 32'd0;
            pending_q  <= 4'd0;
            enable_q   <= 4'd0;
            cnt_q      <= 32'd0;
            reload_q   <= 32'd0;
            ctrl_q     <= 2'd0;
            src_prev_q <= 3'd0;
        end else begin
            dat_o_q    <= dat_o_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            ctrl_q     <= ctrl_d;
            src_prev_q <= src_prev_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_timer_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_timer_slave
//  Purpose  : Self-checking bench for irq_timer_slave. Bus transfers push
//             their expected response into a queue; a monitor pops and
//             compares on every ack. Interrupt lines are checked directly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_timer_slave;

    localparam logic [31:0] BASE = 32'hFFFF_FF00;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        stb_i = 1'b0;
    logic        we_i = 1'b0;
    logic [31:0] adr_i = 32'd0;
    logic [31:0] dat_i = 32'd0;
    logic [3:0]  sel_i = 4'd0;
    logic [31:0] dat_o;
    logic        ack_o;
    logic [2:0]  src_i = 3'd0;
    logic [3:0]  irq;
    logic [3:0]  irqack = 4'd0;

    irq_timer_slave #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .stb_i  (stb_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .dat_i  (dat_i),
        .sel_i  (sel_i),
        .dat_o  (dat_o),
        .ack_o  (ack_o),
        .src_i  (src_i),
        .irq    (irq),
        .irqack (irqack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_read;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total = 0;
    int          bad = 0;
    int          ack_cnt = 0;
    logic        prev_ack = 1'b0;
    logic [31:0] last_rd = 32'd0;

    // ------------------------------------------------------------------
    // Monitor: every ack pops one expectation
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst_ni) begin
            prev_ack = 1'b0;
            last_rd  = 32'd0;
        end else if (ack_o) begin
            ack_cnt++;
            total++;
            if (prev_ack) begin
                bad++;
                $display("FAIL ack_width: ack_o actual=high for 2 cycles required=1 cycle");
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ack: actual=ack required=no ack (t=%0t)", $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_read) begin
                    if (dat_o !== mon_e.data) begin
                        bad++;
                        $display("FAIL read_data: actual=%h required=%h (t=%0t)",
                                 dat_o, mon_e.data, $time);
                    end
                    last_rd = mon_e.data;
                end else if (dat_o !== last_rd) begin
                    bad++;
                    $display("FAIL dat_o_hold: actual=%h required=%h (t=%0t)",
                             dat_o, last_rd, $time);
                end
            end
            prev_ack = 1'b1;
        end else begin
            prev_ack = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // One bus transfer; extra_hold keeps the strobe up that many further
    // cycles after the initiator's normal one-cycle hold.
    task automatic bus(input logic we, input logic [7:0] off, input logic [31:0] wd,
                       input logic [3:0] sel, input logic [31:0] exp_rd,
                       input int extra_hold);
        bit got;
        exp_t e;
        @(posedge clk); #1;
        stb_i = 1'b1;
        we_i  = we;
        adr_i = {BASE[31:8], off};
        dat_i = wd;
        sel_i = sel;
        e.is_read = ~we;
        e.data    = exp_rd;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (ack_o) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: actual=no ack required=ack (off=%h)", off);
            void'(exp_q.pop_back());
        end else begin
            @(posedge clk); #1;
            repeat (extra_hold) begin
                @(posedge clk); #1;
            end
        end
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] sel);
        bus(1'b1, off, wd, sel, 32'd0, 0);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp_rd);
        bus(1'b0, off, 32'd0, 4'hF, exp_rd, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int a0;
        int n;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack_o, 0);
        chk("rst_dat", dat_o, 0);
        chk("rst_irq", irq, 0);
        rst_ni = 1'b1;

        // All registers and reserved offsets read 0
        for (int k = 0; k < 8; k++) begin
            rd(8'(k * 4), 32'd0);
        end
        wr(8'h18, 32'hFFFF_FFFF, 4'hF);

        // Strobe held two extra cycles: exactly one ack
        a0 = ack_cnt;
        bus(1'b0, 8'h04, 32'd0, 4'hF, 32'd0, 2);
        repeat (3) @(posedge clk);
        #1;
        chk("held_stb_acks", ack_cnt - a0, 1);

        // Byte-lane writes
        wr(8'h04, 32'h0000_000F, 4'b0001);
        wr(8'h0C, 32'h1234_5678, 4'b0100);
        rd(8'h0C, 32'h0034_0000);
        rd(8'h04, 32'h0000_000F);

        // Auto-reload timer, period 4
        wr(8'h0C, 32'd3, 4'hF);
        wr(8'h08, 32'd3, 4'hF);
        wr(8'h04, 32'd1, 4'hF);
        wr(8'h10, 32'd3, 4'hF);
        n = 0;
        while (!irq[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmr_first_irq", irq[0], 1);
        irqack = 4'b0001;
        @(posedge clk); #1;
        irqack = 4'b0000;
        chk("tmr_irqack_clr", irq[0], 0);
        n = 0;
        while (!irq[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("tmr_period", n + 1, 4);
        irqack = 4'b0001;
        @(posedge clk); #1;
        chk("tmr_ack_held_clr", irq[0], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("tmr_set_wins", irq[0], 1);
        irqack = 4'b0000;
        wr(8'h10, 32'd0, 4'hF);
        wr(8'h00, 32'hF, 4'b0001);
        rd(8'h00, 32'd0);

        // One-shot
        wr(8'h08, 32'd2, 4'hF);
        wr(8'h10, 32'd1, 4'hF);
        repeat (5) @(posedge clk);
        rd(8'h00, 32'h1);
        rd(8'h10, 32'h0);
        rd(8'h08, 32'h0);
        wr(8'h00, 32'h1, 4'b0001);
        repeat (10) @(posedge clk);
        rd(8'h00, 32'h0);

        // External edge on src_i[1], masked then unmasked
        wr(8'h04, 32'd0, 4'hF);
        @(posedge clk); #1;
        src_i = 3'b010;
        repeat (10) @(posedge clk);
        #1;
        chk("src_masked_irq", irq, 0);
        src_i = 3'b000;
        repeat (2) @(posedge clk);
        rd(8'h00, 32'h4);
        wr(8'h04, 32'h4, 4'b0001);
        chk("src_irq2_set", irq, 4'b0100);
        wr(8'h00, 32'h4, 4'b0001);
        chk("src_irq2_clr", irq, 4'b0000);

        // Address outside window
        a0 = ack_cnt;
        @(posedge clk); #1;
        stb_i = 1'b1;
        we_i  = 1'b0;
        adr_i = BASE + 32'h100;
        repeat (4) @(posedge clk);
        #1;
        stb_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("miss_no_ack", ack_cnt - a0, 0);

        // Reset during ACK
        @(posedge clk); #1;
        stb_i = 1'b1;
        we_i  = 1'b1;
        adr_i = {BASE[31:8], 8'h04};
        dat_i = 32'hF;
        sel_i = 4'hF;
        @(posedge clk); #1;
        chk("rst_mid_ack_before", ack_o, 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_ack_drop", ack_o, 0);
        stb_i = 1'b0;
        we_i  = 1'b0;
        @(posedge clk); #1;
        rst_ni = 1'b1;
        rd(8'h04, 32'h0);

        repeat (4) @(posedge clk);
        #1;
        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_timer_slave.md
# irq_timer_slave

Bus responder that answers the CPU's strobe/acknowledge bus and drives its four-line `irq` / `irqack` interrupt interface. It holds a 4-source pending/enable interrupt controller: source 0 is an internal 32-bit down-counting timer, and sources 1–3 are external rising-edge inputs. It sits on the CPU data bus at a fixed I/O window and is the far end of both the bus initiator and the interrupt acknowledge.

## Interface
Parameters:
- `BASE_ADDR`, default 32'hFFFF_FF00: window base. The block decodes `adr_i[31:8] == BASE_ADDR[31:8]`.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `stb_i`  in  1  bus strobe from the initiator.
- `we_i`  in  1  1 = write, 0 = read.
- `adr_i`  in  32  byte address. `adr_i[4:2]` selects the register; `adr_i[1:0]` is ignored.
- `dat_i`  in  32  write data.
- `sel_i`  in  4  byte-lane enables; bit n enables `dat_i[8n+7:8n]`.
- `dat_o`  out  32  read data. It is held stable until the next read is accepted.
- `ack_o`  out  1  one-cycle acknowledge.
- `src_i`  in  3  external interrupt sources, already synchronous to `clk`.
- `irq`  out  4  interrupt request to the CPU; `irq = pending & enable`.
- `irqack`  in  4  one-hot acknowledge from the CPU. It may stay high for several cycles.

## Operation
Register map (offset, name, behaviour):
- 0x00 `STATUS[3:0]`: pending bits. Read returns the pending bits. Write is write-1-to-clear, masked by `sel_i[0]`.
- 0x04 `ENABLE[3:0]`: per-source mask. Read/write.
- 0x08 `CNT[31:0]`: timer count. Read/write.
- 0x0C `RELOAD[31:0]`: timer reload value. Read/write.
- 0x10 `CTRL[1:0]`: bit0 = `EN`, bit1 = `AR` (auto-reload). Read/write.
- Offsets 0x14–0x1C: read 0, writes ignored, still acknowledged.
- Register writes honour `sel_i` per byte lane. Unused register bits read 0.

Bus state machine: IDLE → ACK → HOLD → IDLE.
- IDLE: when `stb_i` is high and the address matches, perform the write or capture the read data into `dat_o`, assert `ack_o`, and go to ACK.
  - A non-matching address is ignored: no ack, stay in IDLE.
- ACK: `ack_o` is high for this cycle only; go to HOLD.
- HOLD: the initiator keeps `stb_i` high for one cycle after seeing the ack. The block ignores `stb_i` here and returns to IDLE only once `stb_i` is sampled low. No second write and no second ack may occur.

Timer (evaluated every cycle while `EN` = 1):
- If `CNT != 0`: `CNT <= CNT - 1`.
- If `CNT == 0`: set `pending[0]`.
  - With `AR` = 1: `CNT <= RELOAD`.
  - With `AR` = 0: clear `EN`, and `CNT` stays 0.
- Resulting period with `AR` = 1 is `RELOAD + 1` cycles.
- A bus write to `CNT` or `CTRL` in the same cycle overrides the timer update for the written byte lanes.

External sources:
- `src_prev` is a register with reset value 0.
- `src_i[k] & ~src_prev[k]` sets `pending[k+1]`.
- Level-high without a new edge does not re-set the bit.

Pending update, per bit:
- Set by an event (timer expiry or edge).
- Cleared by `irqack[k]` high or by a W1C write with 1 in bit k.
- Set wins over clear in the same cycle.
- `pending` is not gated by `ENABLE`: masked events still latch.

## Timing
- Reset values: `ack_o` = 0, `dat_o` = 0, `irq` = 0, all registers 0, `src_prev` = 0, state IDLE. Asserting `rst_ni` mid-transfer drops `ack_o` immediately and returns the state machine to IDLE.
- Bus latency: `stb_i` sampled high in IDLE gives `ack_o` high the next cycle. Write data takes effect on that same edge; read `dat_o` is valid in the ack cycle and every cycle after it until the next accepted read.
- Minimum spacing between back-to-back accepted transfers is 3 cycles: IDLE, ACK, HOLD, with a further wait in HOLD while `stb_i` stays high.
- `irq` is the AND of two flops, so it reflects an event one cycle after the event edge. `irqack` clears the pending bit at the next edge, and `irq` falls in the cycle after `irqack` is first seen.
- The timer decrements every clock. No prescaler.

## Test plan
- Reset then read each register: every read returns 0, `ack_o` is high for exactly one cycle per read, and a strobe held for 2 cycles after the ack produces no second ack.
- Write `ENABLE` = 0xF with `sel_i` = 4'b0001, then write `RELOAD` = 0x1234_5678 with `sel_i` = 4'b0100 → `RELOAD` reads 0x0034_0000 and `ENABLE` reads 0xF.
- `RELOAD` = 3, `CNT` = 3, `CTRL` = 3, `ENABLE` = 1 → `irq[0]` rises every 4 cycles. Pulsing `irqack` = 4'b0001 clears it, and an expiry coinciding with `irqack` leaves `pending[0]` = 1.
- `CNT` = 2, `CTRL` = 1 (one-shot) → exactly one `pending[0]` set, after which `CTRL` reads 0 and `CNT` reads 0.
- `src_i[1]` held high for 10 cycles with `ENABLE` = 0 → `STATUS` = 4'b0100 and `irq` = 0. Then set `ENABLE` = 4'b0100 → `irq[2]` = 1. Write `STATUS` = 4'b0100 → `irq[2]` = 0.
- Access at address `BASE_ADDR` + 0x100 → no ack. Assert `rst_ni` low during the ACK state → `ack_o` = 0 immediately and the next strobe is acknowledged normally.
